// File: rtl/pwm_song_controller_pkg.sv
// Shared song/note definitions: note codes, ROM word layout, FSM states.
// Pure declarations, no logic and no latency.
// Imported by the controller, its interface and the bench.
package pwm_song_controller_pkg;

  // Note code width and ROM word field positions
  localparam int NOTE_W   = 6;
  localparam int LEN_W    = 5;
  localparam int NOTE_LSB = 0;
  localparam int LEN_LSB  = 6;
  localparam int END_BIT  = 15;

  // Note codes: semitones counted up from C4 = 1; code 0 is a rest
  localparam logic [NOTE_W-1:0] NOTE_RST = 6'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4  = 6'd1;
  localparam logic [NOTE_W-1:0] NOTE_E4  = 6'd5;
  localparam logic [NOTE_W-1:0] NOTE_FS4 = 6'd7;
  localparam logic [NOTE_W-1:0] NOTE_A4  = 6'd10;
  localparam logic [NOTE_W-1:0] NOTE_CS5 = 6'd14;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  // Build a ROM word from a note, its length-1 in 32nds and the end flag
  function automatic logic [15:0] song_word(input logic [NOTE_W-1:0] note,
                                            input logic [LEN_W-1:0] len_m1,
                                            input logic last);
    logic [15:0] w;
    w = '0;
    w[NOTE_LSB +: NOTE_W] = note;
    w[LEN_LSB +: LEN_W]   = len_m1;
    w[END_BIT]            = last;
    return w;
  endfunction

endpackage

// File: rtl/pwm_song_controller_if.sv
// Control, song ROM and note output signals of the song controller.
// Wires only, no latency.
// ROM word is expected one cycle after the address; no other handshake.
interface pwm_song_controller_if #(parameter int ADDR_W = 8);
  import pwm_song_controller_pkg::*;

  logic              i_play;
  logic              i_stop;
  logic              i_loop;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [15:0]       i_rom_data;
  logic [NOTE_W-1:0] o_note;
  logic              o_note_valid;
  logic              o_gate;
  logic              o_busy;
  logic              o_done;

  // Controller side
  modport slave (
    input  i_play, i_stop, i_loop, i_rom_data,
    output o_rom_addr, o_note, o_note_valid, o_gate, o_busy, o_done
  );

  // Host/ROM side
  modport master (
    output i_play, i_stop, i_loop, i_rom_data,
    input  o_rom_addr, o_note, o_note_valid, o_gate, o_busy, o_done
  );

endinterface

// File: rtl/note_duration_counter.sv
// Counts one note's duration in 32nds x ticks; flags last cycle and gap window.
// expire/below_gap are combinational from the count registers.
// No backpressure; counts every cycle while run is high.
module note_duration_counter
  import pwm_song_controller_pkg::*;
#(
  parameter int TICKS_PER_32ND = 1_562_500,
  parameter int GAP_CYCLES     = 250_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [LEN_W-1:0] len,
  output logic             expire,
  output logic             below_gap
);

  localparam int TICK_W = $clog2(TICKS_PER_32ND + 1);
  localparam int REM_W  = $clog2(32 * TICKS_PER_32ND + 1);

  // tick counts TICKS..1 inside a 32nd; n32 counts 32nds left including the current one
  logic [TICK_W-1:0] tick;
  logic [5:0]        n32;
  logic [REM_W-1:0]  remaining;

  // Load a fresh duration, then step down one cycle at a time while playing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= '0;
      n32  <= '0;
    end else if (load) begin
      tick <= TICK_W'(TICKS_PER_32ND);
      n32  <= {1'b0, len} + 6'd1;
    end else if (run) begin
      if (tick == TICK_W'(1)) begin
        tick <= TICK_W'(TICKS_PER_32ND);
        n32  <= n32 - 6'd1;
      end else begin
        tick <= tick - TICK_W'(1);
      end
    end
  end

  // Cycles left in the note including the current one
  assign remaining = REM_W'(n32) * REM_W'(TICKS_PER_32ND) - REM_W'(TICKS_PER_32ND) + REM_W'(tick);
  assign expire    = run && (n32 == 6'd1) && (tick == TICK_W'(1));
  assign below_gap = 32'(remaining) <= 32'(GAP_CYCLES);

endmodule

// File: rtl/pwm_song_controller.sv
// Walks a song ROM and plays each note for its length, gating off the tail gap.
// i_play to first PLAY cycle is 3 cycles; ROM read latency is 1 cycle.
// No backpressure; i_stop aborts in any state and beats a same-cycle i_play.
module pwm_song_controller
  import pwm_song_controller_pkg::*;
#(
  parameter int TICKS_PER_32ND = 1_562_500,
  parameter int GAP_CYCLES     = 250_000,
  parameter int ADDR_W         = 8
) (
  input logic                  i_clk,
  input logic                  i_rst,
  pwm_song_controller_if.slave bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [NOTE_W-1:0] note_q;
  logic              done_q, done_nxt;
  logic              cnt_load, cnt_expire, cnt_below_gap;
  logic              end_word;
  logic              unused_rom_bits;

  assign end_word        = bus.i_rom_data[END_BIT];
  assign unused_rom_bits = ^bus.i_rom_data[END_BIT-1:LEN_LSB+LEN_W];

  note_duration_counter #(
    .TICKS_PER_32ND(TICKS_PER_32ND),
    .GAP_CYCLES    (GAP_CYCLES)
  ) u_dur (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (cnt_load),
    .run      (state == PLAY),
    .len      (bus.i_rom_data[LEN_LSB +: LEN_W]),
    .expire   (cnt_expire),
    .below_gap(cnt_below_gap)
  );

  // State, song address, current note and the done pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      addr   <= '0;
      note_q <= NOTE_RST;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      done_q <= done_nxt;
      if (cnt_load) note_q <= bus.i_rom_data[NOTE_LSB +: NOTE_W];
    end
  end

  // Next-state logic; stop overrides every transition and suppresses done
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    cnt_load  = 1'b0;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_play) begin
          state_nxt = FETCH;
          addr_nxt  = '0;
        end
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        if (!end_word) begin
          cnt_load  = 1'b1;
          state_nxt = PLAY;
        end else if (bus.i_loop && (addr != '0)) begin
          // Looping an empty song would spin forever, hence the addr check
          addr_nxt  = '0;
          state_nxt = FETCH;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      PLAY: begin
        if (cnt_expire) begin
          addr_nxt  = addr + ADDR_W'(1);
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.i_stop) begin
      state_nxt = IDLE;
      cnt_load  = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  assign bus.o_rom_addr   = addr;
  assign bus.o_note       = note_q;
  assign bus.o_note_valid = (state == PLAY);
  assign bus.o_gate       = (state == PLAY) && (note_q != NOTE_RST) && !cnt_below_gap;
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_done       = done_q;

endmodule

// File: tb/tb_pwm_song_controller.sv
// Scoreboard bench: a note-level model pushes expected events when play is
// issued; a negedge monitor pushes observed valid-windows for comparison.
module tb_pwm_song_controller;
  import pwm_song_controller_pkg::*;

  localparam int TICKS = 4;
  localparam int GAP   = 1;
  localparam logic [15:0] END_WORD = 16'h8000;

  typedef struct {
    int addr;
    int note;
    int start;
    int vlen;
    int glen;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] rom [0:255];
  ev_t exp_q[$];
  ev_t obs_q[$];

  int   done_total = 0;
  int   done_cyc   = -1;
  bit   in_note    = 1'b0;
  ev_t  cur;

  pwm_song_controller_if #(.ADDR_W(8)) bus();

  pwm_song_controller #(
    .TICKS_PER_32ND(TICKS),
    .GAP_CYCLES    (GAP),
    .ADDR_W        (8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous song ROM: data one cycle after address
  always @(posedge clk) bus.i_rom_data <= rom[bus.o_rom_addr];

  // Monitor: each contiguous o_note_valid window becomes one observed event
  always @(negedge clk) begin
    if (bus.o_done) begin
      done_total = done_total + 1;
      done_cyc   = cyc;
    end
    if (bus.o_note_valid) begin
      if (!in_note) begin
        in_note   = 1'b1;
        cur.addr  = int'(bus.o_rom_addr);
        cur.note  = int'(bus.o_note);
        cur.start = cyc;
        cur.vlen  = 0;
        cur.glen  = 0;
      end
      cur.vlen = cur.vlen + 1;
      if (bus.o_gate) cur.glen = cur.glen + 1;
    end else if (in_note) begin
      in_note = 1'b0;
      obs_q.push_back(cur);
    end
  end

  function automatic void clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = END_WORD;
  endfunction

  // Reference model: expected note events for the ROM contents, play at cycle p
  function automatic void push_model(input int p);
    int start;
    ev_t e;
    start = p + 3;
    for (int i = 0; i < 256; i++) begin
      if (rom[i][15]) break;
      e.addr  = i;
      e.note  = int'(rom[i][5:0]);
      e.start = start;
      e.vlen  = (int'(rom[i][10:6]) + 1) * TICKS;
      e.glen  = (e.note == int'(NOTE_RST)) ? 0 : ((e.vlen > GAP) ? e.vlen - GAP : 0);
      exp_q.push_back(e);
      start   = start + e.vlen + 2;
    end
  endfunction

  task automatic pulse(input bit pl, input bit st, output int c);
    @(posedge clk); #1;
    bus.i_play = pl;
    bus.i_stop = st;
    c = cyc;
    @(posedge clk); #1;
    bus.i_play = 1'b0;
    bus.i_stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic wait_events(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks += 6;
    if (bus.o_rom_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.o_rom_addr); end
    if (bus.o_note !== NOTE_RST) begin errors++; $display("FAIL reset_note: got %0d want %0d", bus.o_note, NOTE_RST); end
    if (bus.o_note_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_note_valid); end
    if (bus.o_gate !== 1'b0) begin errors++; $display("FAIL reset_gate: got %b want 0", bus.o_gate); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int p, d0;
    bit ok;
    ev_t e, o;
    clear_rom();
    rom[0] = song_word(NOTE_FS4, 5'd1, 1'b0);
    rom[1] = song_word(NOTE_CS5, 5'd0, 1'b0);
    d0 = done_total;
    pulse(1'b1, 1'b0, p);
    push_model(p);
    wait_idle(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: busy still 1 after 100 cycles, want 0"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL basic_missing_event: got none want addr %0d", e.addr);
      end else begin
        o = obs_q.pop_front();
        checks += 4;
        if (o.addr !== e.addr) begin errors++; $display("FAIL basic_addr: got %0d want %0d", o.addr, e.addr); end
        if (o.note !== e.note) begin errors++; $display("FAIL basic_note: got %0d want %0d", o.note, e.note); end
        if (o.start - p !== e.start - p) begin errors++; $display("FAIL basic_start: got %0d want %0d", o.start - p, e.start - p); end
        if (o.vlen !== e.vlen || o.glen !== e.glen) begin
          errors++; $display("FAIL basic_len: got valid %0d gate %0d want valid %0d gate %0d", o.vlen, o.glen, e.vlen, e.glen);
        end
      end
    end
    checks += 3;
    if (obs_q.size() != 0) begin errors++; $display("FAIL basic_extra_events: got %0d want 0", obs_q.size()); end
    if (done_total - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_total - d0); end
    if (done_cyc - p != 19) begin errors++; $display("FAIL basic_done_cycle: got %0d want 19", done_cyc - p); end
    obs_q.delete();
  endtask

  task automatic test_rest();
    int p;
    bit ok;
    ev_t e, o;
    clear_rom();
    rom[0] = song_word(NOTE_RST, 5'd0, 1'b0);
    pulse(1'b1, 1'b0, p);
    push_model(p);
    wait_idle(100, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || obs_q.size() != 1) begin
      errors++; $display("FAIL rest_events: got %0d events want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      checks += 2;
      if (o.vlen !== e.vlen) begin errors++; $display("FAIL rest_valid_len: got %0d want %0d", o.vlen, e.vlen); end
      if (o.glen !== 0) begin errors++; $display("FAIL rest_gate_len: got %0d want 0", o.glen); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_loop();
    int p, d0, c;
    bit ok;
    ev_t o;
    int exp_addr [5] = '{0, 1, 0, 1, 0};
    clear_rom();
    rom[0] = song_word(NOTE_E4, 5'd0, 1'b0);
    rom[1] = song_word(NOTE_A4, 5'd0, 1'b0);
    bus.i_loop = 1'b1;
    d0 = done_total;
    pulse(1'b1, 1'b0, p);
    wait_events(5, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL loop_timeout: got %0d events want 5", obs_q.size()); end
    pulse(1'b0, 1'b1, c);
    bus.i_loop = 1'b0;
    wait_idle(20, ok);
    for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      checks++;
      if (o.addr !== exp_addr[i]) begin errors++; $display("FAIL loop_addr[%0d]: got %0d want %0d", i, o.addr, exp_addr[i]); end
      if (i == 2) begin
        checks++;
        if (o.start - p !== 17) begin errors++; $display("FAIL loop_restart_cycle: got %0d want 17", o.start - p); end
      end
    end
    checks++;
    if (done_total != d0) begin errors++; $display("FAIL loop_done: got %0d pulses want 0", done_total - d0); end
    obs_q.delete();
  endtask

  task automatic test_empty();
    int p, d0;
    bit ok;
    clear_rom();
    bus.i_loop = 1'b1;
    d0 = done_total;
    pulse(1'b1, 1'b0, p);
    wait_idle(10, ok);
    bus.i_loop = 1'b0;
    checks += 3;
    if (!ok) begin errors++; $display("FAIL empty_hang: busy still 1, want 0"); end
    if (done_total - d0 != 1) begin errors++; $display("FAIL empty_done_count: got %0d want 1", done_total - d0); end
    else if (done_cyc - p > 3) begin errors++; $display("FAIL empty_done_cycle: got %0d want <=3", done_cyc - p); end
    if (obs_q.size() != 0) begin errors++; $display("FAIL empty_events: got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_stop();
    int p, p2, c, d0;
    bit ok;
    ev_t o;
    ev_t e;
    clear_rom();
    rom[0] = song_word(NOTE_FS4, 5'd1, 1'b0);
    rom[1] = song_word(NOTE_CS5, 5'd0, 1'b0);
    d0 = done_total;
    pulse(1'b1, 1'b0, p);
    exp_q.push_back('{0, int'(NOTE_FS4), p + 3, 8, 7});
    exp_q.push_back('{1, int'(NOTE_CS5), p + 13, 2, 2});
    repeat (13) @(posedge clk);
    #1 bus.i_stop = 1'b1;
    @(posedge clk); #1 bus.i_stop = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b want 0", bus.o_busy); end
    if (bus.o_note_valid !== 1'b0) begin errors++; $display("FAIL stop_valid: got %b want 0", bus.o_note_valid); end
    if (bus.o_gate !== 1'b0) begin errors++; $display("FAIL stop_gate: got %b want 0", bus.o_gate); end
    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL stop_missing_event: got none want addr %0d", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.vlen !== e.vlen || o.glen !== e.glen || o.start !== e.start) begin
          errors++;
          $display("FAIL stop_event: got addr %0d start %0d valid %0d gate %0d want addr %0d start %0d valid %0d gate %0d",
                   o.addr, o.start - p, o.vlen, o.glen, e.addr, e.start - p, e.vlen, e.glen);
        end
      end
    end
    checks++;
    if (done_total != d0) begin errors++; $display("FAIL stop_done: got %0d pulses want 0", done_total - d0); end
    pulse(1'b1, 1'b1, c);
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL stop_beats_play: busy got %b want 0", bus.o_busy); end
    pulse(1'b1, 1'b0, p2);
    wait_events(1, 30, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stop_replay_timeout: got 0 events want 1");
    end else begin
      o = obs_q.pop_front();
      if (o.addr !== 0 || o.start - p2 !== 3) begin
        errors++; $display("FAIL stop_replay: got addr %0d start %0d want addr 0 start 3", o.addr, o.start - p2);
      end
    end
    pulse(1'b0, 1'b1, c);
    wait_idle(10, ok);
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    int p, c, d0;
    bit ok;
    ev_t o;
    clear_rom();
    rom[0] = song_word(NOTE_FS4, 5'd1, 1'b0);
    rom[1] = song_word(NOTE_CS5, 5'd0, 1'b0);
    d0 = done_total;
    pulse(1'b1, 1'b0, p);
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks += 6;
    if (bus.o_note_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", bus.o_note_valid); end
    if (bus.o_gate !== 1'b0) begin errors++; $display("FAIL arst_gate: got %b want 0", bus.o_gate); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", bus.o_busy); end
    if (bus.o_note !== NOTE_RST) begin errors++; $display("FAIL arst_note: got %0d want %0d", bus.o_note, NOTE_RST); end
    if (bus.o_rom_addr !== 8'd0) begin errors++; $display("FAIL arst_addr: got %0d want 0", bus.o_rom_addr); end
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", bus.o_done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs_q.delete();
    pulse(1'b1, 1'b0, p);
    wait_events(1, 30, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL arst_replay_timeout: got 0 events want 1");
    end else begin
      o = obs_q.pop_front();
      if (o.addr !== 0 || int'(o.note) !== int'(NOTE_FS4)) begin
        errors++; $display("FAIL arst_replay: got addr %0d note %0d want addr 0 note %0d", o.addr, o.note, NOTE_FS4);
      end
    end
    pulse(1'b0, 1'b1, c);
    wait_idle(10, ok);
    checks++;
    if (done_total != d0) begin errors++; $display("FAIL arst_done_count: got %0d pulses want 0", done_total - d0); end
    obs_q.delete();
  endtask

  task automatic test_wrap();
    int p, c;
    bit ok;
    ev_t o;
    for (int i = 0; i < 256; i++) rom[i] = song_word(NOTE_FS4, 5'd0, 1'b0);
    pulse(1'b1, 1'b0, p);
    for (int i = 0; i < 257; i++) exp_q.push_back('{i % 256, int'(NOTE_FS4), 0, 4, 3});
    wait_events(257, 2500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_timeout: got %0d events want 257", obs_q.size()); end
    pulse(1'b0, 1'b1, c);
    wait_idle(10, ok);
    for (int i = 0; i < 257 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      cur = exp_q.pop_front();
      checks++;
      if (o.addr !== cur.addr || o.vlen !== cur.vlen) begin
        errors++; $display("FAIL wrap_event[%0d]: got addr %0d valid %0d want addr %0d valid %0d", i, o.addr, o.vlen, cur.addr, cur.vlen);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    bus.i_play = 1'b0;
    bus.i_stop = 1'b0;
    bus.i_loop = 1'b0;
    clear_rom();
    test_reset();
    test_basic();
    test_rest();
    test_loop();
    test_empty();
    test_stop();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_song_controller.md
PWM_SONG_CONTROLLER -- requirements
Module: pwm_song_controller

Interface
REQ-001 Parameter TICKS_PER_32ND, default 1_562_500: clock cycles per 1/32 note (120 BPM at 25 MHz).
REQ-002 Parameter GAP_CYCLES, default 250_000: articulation gap; gate low for the final GAP_CYCLES of each note.
REQ-003 Parameter ADDR_W, default 8: song ROM address width.
REQ-004 i_clk  input  1  sole clock; all state on rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_play  input  1  one-cycle start pulse.
REQ-007 i_stop  input  1  one-cycle abort pulse.
REQ-008 i_loop  input  1  level; restart at address 0 on end marker.
REQ-009 o_rom_addr  output  ADDR_W  song ROM address.
REQ-010 i_rom_data  input  16  ROM word, valid one cycle after o_rom_addr; [5:0] note code, [10:6] length-1 in 32nds, [15] end marker, others ignored.
REQ-011 o_note  output  6  note code for the note_table lookup.
REQ-012 o_note_valid  output  1  high while o_note is the note currently playing.
REQ-013 o_gate  output  1  high while the note sounds.
REQ-014 o_busy  output  1  high in any state except IDLE.
REQ-015 o_done  output  1  one-cycle pulse on natural song end.

Function
REQ-016 States IDLE, FETCH, LOAD, PLAY; encoding is free.
REQ-017 IDLE: i_play -> FETCH with address 0; otherwise stay.
REQ-018 FETCH: drive o_rom_addr with the current address; next state LOAD.
REQ-019 LOAD, word without end marker: capture note and length into o_note and the duration counter; go to PLAY.
REQ-020 LOAD, end marker with i_loop=1 and address != 0: address <= 0, go to FETCH.
REQ-021 LOAD, end marker with i_loop=0, or at address 0 (empty song): go to IDLE and pulse o_done for one cycle.
REQ-022 PLAY lasts exactly (len+1)*TICKS_PER_32ND cycles, then address+1 and FETCH.
REQ-023 Address wraps from 2^ADDR_W-1 to 0 without an error.
REQ-024 o_note_valid=1 only in PLAY; o_note holds its last value in all other states.
REQ-025 o_gate=1 in PLAY only when note != NOTE_RST and remaining cycles > GAP_CYCLES.
REQ-026 If GAP_CYCLES >= note duration, o_gate stays 0 for that note.
REQ-027 Latency: i_play at cycle N -> FETCH at N+1, LOAD at N+2, PLAY (valid, gate) from N+3.
REQ-028 i_stop in any state -> IDLE next cycle; gate and valid drop; o_done not pulsed.
REQ-029 i_stop and i_play in the same cycle: stop wins.
REQ-030 i_play while busy is ignored.
REQ-031 Duration counting uses an internal count register; the 32nd counter is at least 6 bits wide so len+1=32 does not overflow.

Reset
REQ-032 On reset: state IDLE, address 0, o_rom_addr 0, o_note NOTE_RST, o_note_valid/o_gate/o_busy/o_done 0, counters 0.
REQ-033 Reset mid-song aborts immediately; the first play after release starts at address 0.

Structure
REQ-034 NOTE_RST, the note-code width and the ROM word field positions (note, length, end bit) live in the shared note header, next to the note codes.
REQ-035 A single sub-module, note_duration_counter (load, len, expire, remaining-below-gap), is natural; the FSM stays in the top module.

Verification
REQ-036 Run with TICKS_PER_32ND=4 and GAP_CYCLES=1.
REQ-037 Scenario, basic play: ROM {Fs4 len 2, Cs5 len 1, end}; play pulse at cycle 0 -> Fs4 valid cycles 3-10, gate cycles 3-9; Cs5 valid from cycle 13 for 4 cycles; o_done pulse once; busy then 0.
REQ-038 Scenario, rest: NOTE_RST len 1 -> valid high 4 cycles, gate never high.
REQ-039 Scenario, loop: i_loop=1, two-note song -> address sequence 0,1,2,0,1,...; o_done never pulses.
REQ-040 Scenario, empty song: end marker at address 0 with i_loop=1 -> IDLE and o_done within 3 cycles of play; no hang.
REQ-041 Scenario, stop: i_stop mid-note (and same cycle as i_play in IDLE) -> IDLE next cycle, gate 0, no o_done; a later play restarts at address 0.
REQ-042 Scenario, async reset: reset asserted mid-PLAY between clock edges -> all outputs reach reset values before the next edge.
